// File: rtl/nubus_slave_ctrl_if.sv
// NuBus slave controller bus bundle: pad-side NuBus signals plus the
// card-local memory handshake, grouped so the controller takes one port.
interface nubus_slave_ctrl_if;
  // NuBus pads (all active low)
  logic        nub_startn;
  logic        nub_ackn;
  logic        nub_tm1n;
  logic        nub_tm0n;
  logic [31:0] nub_adn;
  logic [3:0]  nub_idn;

  // Memory fabric responses
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // Memory fabric requests
  logic        mem_valid_o;
  logic [3:0]  mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_myslot;
  logic        mem_myexp;

  // Slave-driven NuBus signals
  logic        slv_slave_o;
  logic        slv_ackn_o;
  logic        slv_tm1n_o;
  logic        slv_tm0n_o;
  logic [31:0] slv_adn_o;
  logic        slv_ad_oe_o;
  logic        slv_err_o;

  modport slave (
    input  nub_startn, nub_ackn, nub_tm1n, nub_tm0n, nub_adn, nub_idn,
    input  mem_ready, mem_rdata,
    output mem_valid_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_myslot, mem_myexp,
    output slv_slave_o, slv_ackn_o, slv_tm1n_o, slv_tm0n_o, slv_adn_o, slv_ad_oe_o,
    output slv_err_o
  );

  modport master (
    output nub_startn, nub_ackn, nub_tm1n, nub_tm0n, nub_adn, nub_idn,
    output mem_ready, mem_rdata,
    input  mem_valid_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_myslot, mem_myexp,
    input  slv_slave_o, slv_ackn_o, slv_tm1n_o, slv_tm0n_o, slv_adn_o, slv_ad_oe_o,
    input  slv_err_o
  );
endinterface

// File: rtl/nubus_slave_ctrl.sv
// NuBus slave controller: decodes slot / super-slot space, runs a registered
// memory handshake with byte-lane enables, and closes every bus cycle with a
// one-cycle ACK carrying complete, error or timeout status.
module nubus_slave_ctrl #(
  parameter logic [3:0]  SLOTS_ADDRESS  = 4'hF,
  parameter bit          SUPER_ENABLE   = 1'b1,
  parameter logic [3:0]  EXPANSION_MASK = 4'hC,
  parameter logic [3:0]  EXPANSION_ADDR = 4'h0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input logic               nub_clkn,
  input logic               nub_reset,
  nubus_slave_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  // Status encodings as {tm1n, tm0n}
  localparam logic [1:0] StatComplete = 2'b00;
  localparam logic [1:0] StatError    = 2'b01;
  localparam logic [1:0] StatTimeout  = 2'b10;
  localparam logic [1:0] StatIdle     = 2'b11;

  // Counter value on the last permitted ACCESS cycle without ready
  localparam logic [TIMEOUT_W-1:0] WaitLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic dec_slot(input logic [31:0] a, input logic [3:0] id);
    return ((a[31:28] == SLOTS_ADDRESS) && (a[27:24] == id)) ||
           (SUPER_ENABLE && (a[31:28] == id) && (id != 4'h0));
  endfunction

  function automatic logic dec_exp(input logic [31:0] a);
    return (a[31:28] & EXPANSION_MASK) == EXPANSION_ADDR;
  endfunction

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  tm1n_q, tm1n_d;
  logic                  tm0n_q, tm0n_d;
  logic                  valid_q, valid_d;
  logic                  first_q, first_d;
  logic [TIMEOUT_W-1:0]  wait_q, wait_d;
  logic [31:0]           adn_q, adn_d;
  logic                  ackn_q, ackn_d;
  logic [1:0]            stat_q, stat_d;
  logic                  ad_oe_q, ad_oe_d;
  logic                  err_q, err_d;

  logic [3:0]  card_id;
  logic [31:0] bus_addr;
  logic        start_hit;
  logic        reserved;
  logic [3:0]  lanes;

  assign card_id   = ~bus.nub_idn;
  assign bus_addr  = ~bus.nub_adn;
  // Attention cycles (START with ACK) never open a transaction
  assign start_hit = !bus.nub_startn && bus.nub_ackn && dec_slot(bus_addr, card_id);
  assign reserved  = bus.nub_tm0n && (bus_addr[1:0] == 2'b11);

  // Next-state, latches and ACK-cycle outputs
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tm1n_d  = tm1n_q;
    tm0n_d  = tm0n_q;
    valid_d = valid_q;
    first_d = first_q;
    wait_d  = wait_q;
    adn_d   = adn_q;
    ackn_d  = 1'b1;
    stat_d  = StatIdle;
    ad_oe_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_hit) begin
          addr_d = bus_addr;
          tm1n_d = bus.nub_tm1n;
          tm0n_d = bus.nub_tm0n;
          wait_d = '0;
          if (reserved) begin
            // Reserved encoding is refused without touching memory
            state_d = StAck;
            ackn_d  = 1'b0;
            stat_d  = StatError;
            err_d   = 1'b1;
          end else begin
            state_d = StAccess;
            valid_d = 1'b1;
            first_d = 1'b1;
          end
        end
      end
      StAccess: begin
        first_d = 1'b0;
        if (first_q) wdata_d = bus_addr;
        // Ready takes priority over an expiring timeout
        if (bus.mem_ready) begin
          state_d = StAck;
          valid_d = 1'b0;
          ackn_d  = 1'b0;
          stat_d  = StatComplete;
          if (tm1n_q) begin
            adn_d   = ~bus.mem_rdata;
            ad_oe_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + TIMEOUT_W'(1);
          if (wait_q == WaitLast) begin
            state_d = StAck;
            valid_d = 1'b0;
            ackn_d  = 1'b0;
            stat_d  = StatTimeout;
            err_d   = 1'b1;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
        wait_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge nub_clkn) begin
    if (nub_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      tm1n_q  <= 1'b1;
      tm0n_q  <= 1'b1;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      wait_q  <= '0;
      adn_q   <= '1;
      ackn_q  <= 1'b1;
      stat_q  <= StatIdle;
      ad_oe_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tm1n_q  <= tm1n_d;
      tm0n_q  <= tm0n_d;
      valid_q <= valid_d;
      first_q <= first_d;
      wait_q  <= wait_d;
      adn_q   <= adn_d;
      ackn_q  <= ackn_d;
      stat_q  <= stat_d;
      ad_oe_q <= ad_oe_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane write enables from the latched mode and address
  always_comb begin
    lanes = 4'b0000;
    if (valid_q && !tm1n_q) begin
      if (!tm0n_q) begin
        lanes = 4'b0001 << addr_q[1:0];
      end else begin
        unique case (addr_q[1:0])
          2'b00:   lanes = 4'b1111;
          2'b01:   lanes = 4'b0011;
          2'b10:   lanes = 4'b1100;
          default: lanes = 4'b0000;
        endcase
      end
    end
  end

  assign bus.mem_valid_o = valid_q;
  assign bus.mem_write_o = lanes;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_myslot  = dec_slot(addr_q, card_id);
  assign bus.mem_myexp   = dec_exp(addr_q);
  assign bus.slv_slave_o = (state_q != StIdle);
  assign bus.slv_ackn_o  = ackn_q;
  assign bus.slv_tm1n_o  = stat_q[1];
  assign bus.slv_tm0n_o  = stat_q[0];
  assign bus.slv_adn_o   = adn_q;
  assign bus.slv_ad_oe_o = ad_oe_q;
  assign bus.slv_err_o   = err_q;

endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// Bench for nubus_slave_ctrl: a driver issues bus cycles and plays the
// memory, pushing the expected ACK of each serviced cycle into a scoreboard;
// a monitor pops and compares whenever the slave acknowledges.
module tb_nubus_slave_ctrl;
  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startn = 1'b1, ackn = 1'b1, tm1n = 1'b1, tm0n = 1'b1, ready = 1'b0;
  logic [31:0] adn = '1, rdata = '0;
  logic [3:0]  id = 4'h3;
  int unsigned cyc = 0;
  int          total = 0, bad = 0;
  int          acks1 = 0, exp_acks1 = 0;
  bit          quiet = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nubus_slave_ctrl_if bus0 ();
  nubus_slave_ctrl_if bus1 ();

  assign bus0.nub_startn = startn;  assign bus1.nub_startn = startn;
  assign bus0.nub_ackn   = ackn;    assign bus1.nub_ackn   = ackn;
  assign bus0.nub_tm1n   = tm1n;    assign bus1.nub_tm1n   = tm1n;
  assign bus0.nub_tm0n   = tm0n;    assign bus1.nub_tm0n   = tm0n;
  assign bus0.nub_adn    = adn;     assign bus1.nub_adn    = adn;
  assign bus0.nub_idn    = ~id;     assign bus1.nub_idn    = ~id;
  assign bus0.mem_ready  = ready;   assign bus1.mem_ready  = ready;
  assign bus0.mem_rdata  = rdata;   assign bus1.mem_rdata  = rdata;

  nubus_slave_ctrl #(.TIMEOUT_CYCLES(T)) dut0 (
    .nub_clkn  (clk),
    .nub_reset (reset),
    .bus       (bus0)
  );

  nubus_slave_ctrl #(.SUPER_ENABLE(1'b0), .TIMEOUT_CYCLES(T)) dut1 (
    .nub_clkn  (clk),
    .nub_reset (reset),
    .bus       (bus1)
  );

  typedef struct {
    int unsigned start;
    int unsigned lat;
    logic [1:0]  st;
    bit          rd;
    bit          mem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  we;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference decode: slot space F<id>, or super-slot <id> when enabled and id nonzero
  function automatic bit hits(input logic [31:0] a, input logic [3:0] cid, input bit sup);
    return (a[31:24] == {4'hF, cid}) || (sup && cid != 4'h0 && a[31:28] == cid);
  endfunction

  // Monitor: compares every ACK of dut0 against the scoreboard head
  exp_t        e;
  bit          valid_seen = 1'b0;
  bit          post_ack = 1'b0;
  logic [3:0]  last_we = '0;

  always @(negedge clk) begin
    if (reset) begin
      valid_seen = 1'b0;
      post_ack   = 1'b0;
      last_we    = '0;
    end else begin
      if (bus1.slv_ackn_o == 1'b0) acks1++;
      if (post_ack) begin
        check("ack_one_cycle", bus0.slv_ackn_o, 1'b1);
        check("valid_after_ack", bus0.mem_valid_o, 1'b0);
        check("oe_after_ack", bus0.slv_ad_oe_o, 1'b0);
        check("err_after_ack", bus0.slv_err_o, 1'b0);
        post_ack = 1'b0;
      end
      if (bus0.mem_valid_o) begin
        if (sb.size() == 0 && !quiet) check("spurious_valid", bus0.mem_valid_o, 1'b0);
        valid_seen = 1'b1;
        last_we    = bus0.mem_write_o;
      end
      if (bus0.slv_ackn_o == 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", bus0.slv_ackn_o, 1'b1);
        end else begin
          e = sb.pop_front();
          check("latency", cyc - e.start, e.lat);
          check("status", {bus0.slv_tm1n_o, bus0.slv_tm0n_o}, e.st);
          check("err_pulse", bus0.slv_err_o, e.st != 2'b00);
          check("ad_oe", bus0.slv_ad_oe_o, e.rd && e.st == 2'b00);
          check("slave", bus0.slv_slave_o, 1'b1);
          check("mem_used", valid_seen, e.mem);
          check("byte_en", last_we, e.we);
          check("addr", bus0.mem_addr_o, e.addr);
          check("myslot", bus0.mem_myslot, 1'b1);
          check("myexp", bus0.mem_myexp, e.addr[31:30] == 2'b00);
          if (e.rd && e.st == 2'b00) check("rdata", bus0.slv_adn_o, ~e.rdata);
          if (!e.rd && e.mem) check("wdata", bus0.mem_wdata_o, e.wdata);
        end
        valid_seen = 1'b0;
        last_we    = '0;
        post_ack   = 1'b1;
      end
    end
  end

  // One bus cycle: start period, then play the memory until the expected ACK
  task automatic xfer(input logic [31:0] addr, input bit rd, input bit m0,
                      input logic [31:0] wd, input logic [31:0] rdd, input int waits,
                      input bit noise);
    exp_t x;
    bit   hit0, rsv;
    int   lat;
    hit0 = hits(addr, id, 1'b1);
    rsv  = m0 && addr[1:0] == 2'b11;
    lat  = rsv ? 1 : ((waits < int'(T)) ? waits + 2 : int'(T) + 1);
    if (hits(addr, id, 1'b0)) exp_acks1++;
    startn = 1'b0; ackn = 1'b1; adn = ~addr; tm1n = rd; tm0n = m0; ready = 1'b0;
    if (hit0) begin
      x.start = cyc;
      x.lat   = lat;
      x.st    = rsv ? 2'b01 : ((waits < int'(T)) ? 2'b00 : 2'b10);
      x.rd    = rd;
      x.mem   = !rsv;
      x.addr  = addr;
      x.wdata = wd;
      x.rdata = rdd;
      if (rd || rsv) x.we = 4'b0000;
      else if (!m0)  x.we = 4'(1 << addr[1:0]);
      else if (addr[1:0] == 2'b00) x.we = 4'b1111;
      else x.we = addr[1] ? 4'b1100 : 4'b0011;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    if (!hit0) begin
      startn = 1'b1; adn = ~wd;
      @(posedge clk); #1;
      adn = '1;
      return;
    end
    for (int k = 1; k <= lat; k++) begin
      adn    = (k == 1) ? ~wd : ~{id, 28'($urandom)};
      startn = !(noise && k >= 2 && $urandom_range(0, 1) == 1);
      ready  = !rsv && k == waits + 1 && k < lat;
      rdata  = ready ? rdd : $urandom;
      @(posedge clk); #1;
    end
    startn = 1'b1; ready = 1'b0; adn = '1;
  endtask

  task automatic check_reset();
    check("rst_valid", bus0.mem_valid_o, 1'b0);
    check("rst_we", bus0.mem_write_o, 4'b0000);
    check("rst_addr", bus0.mem_addr_o, 32'h0);
    check("rst_wdata", bus0.mem_wdata_o, 32'h0);
    check("rst_ackn", bus0.slv_ackn_o, 1'b1);
    check("rst_tm1n", bus0.slv_tm1n_o, 1'b1);
    check("rst_tm0n", bus0.slv_tm0n_o, 1'b1);
    check("rst_slave", bus0.slv_slave_o, 1'b0);
    check("rst_oe", bus0.slv_ad_oe_o, 1'b0);
    check("rst_adn", bus0.slv_adn_o, 32'hFFFF_FFFF);
    check("rst_err", bus0.slv_err_o, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cycles
    xfer(32'hF300_0010, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    xfer(32'hF300_0013, 1'b0, 1'b0, 32'hAABB_CCDD, 32'h0, 0, 1'b0);
    xfer(32'hF300_0011, 1'b0, 1'b1, 32'h1111_2222, 32'h0, 1, 1'b0);
    xfer(32'hF300_0012, 1'b0, 1'b1, 32'h3333_4444, 32'h0, 0, 1'b0);
    xfer(32'hF300_0000, 1'b1, 1'b1, 32'h0, 32'h1234_5678, 3, 1'b0);
    xfer(32'h3000_0000, 1'b1, 1'b1, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
    xfer(32'hF400_0000, 1'b1, 1'b1, 32'h0, 32'h0, 0, 1'b0);
    xfer(32'hF300_0020, 1'b0, 1'b1, 32'h5555_AAAA, 32'h0, 10, 1'b0);
    xfer(32'hF300_0003, 1'b0, 1'b1, 32'h7777_8888, 32'h0, 0, 1'b0);
    xfer(32'hF300_0004, 1'b1, 1'b1, 32'h0, 32'h0BAD_F00D, 2, 1'b1);
    id = 4'h0;
    xfer(32'h0000_0000, 1'b1, 1'b1, 32'h0, 32'h0, 0, 1'b0);
    id = 4'h3;
    // Attention cycle with a matching address
    startn = 1'b0; ackn = 1'b0; adn = ~32'hF300_0010;
    @(posedge clk); #1;
    startn = 1'b1; ackn = 1'b1; adn = '1;
    @(posedge clk); #1;

    // Reset in the middle of ACCESS
    quiet = 1'b1;
    startn = 1'b0; adn = ~32'hF300_0020; tm1n = 1'b0; tm0n = 1'b1;
    @(posedge clk); #1;
    startn = 1'b1; adn = ~32'h0123_4567;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    quiet = 1'b0;
    xfer(32'hF300_0030, 1'b0, 1'b1, 32'h600D_CAFE, 32'h0, 1, 1'b0);

    // Randomized cycles
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: a = {8'hF3, 24'($urandom)};
        1: a = {4'h3, 28'($urandom)};
        2: a = {8'hF4, 24'($urandom)};
        default: a = {4'($urandom_range(4, 14)), 28'($urandom)};
      endcase
      xfer(a, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom_range(0, 6),
           1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        startn = 1'($urandom); ackn = 1'b0; adn = ~{8'hF3, 24'($urandom)};
        @(posedge clk); #1;
        startn = 1'b1; ackn = 1'b1; adn = '1;
      end
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("no_super_acks", acks1, exp_acks1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nubus_slave_ctrl.md
Name: nubus_slave_ctrl

Overview:
Second-generation NuBus slave controller for the card.
- Decodes standard slot space and, optionally, super-slot space.
- Runs a registered memory handshake with per-lane byte enables.
- Returns read data on AD and completes every cycle with an explicit NuBus status (complete / error / timeout).
- Enforces a programmable wait-state timeout so a stalled memory cannot hang the bus.
- Sits between the NuBus pads and the card-local memory/ROM/register fabric.

Parameters:
- SLOTS_ADDRESS, 'hF: value of addr[31:28] selecting standard slot space.
- SUPER_ENABLE, 1: 1 = also respond when addr[31:28] == card ID (ID 0 never matches).
- EXPANSION_MASK, 'hC: mask applied to addr[31:28] for the expansion window.
- EXPANSION_ADDR, 'h0: compare value for the expansion window.
- TIMEOUT_CYCLES, 255: maximum clocks in ACCESS without mem_ready; 1..2^TIMEOUT_W-1.
- TIMEOUT_W, 8: wait counter width.

Ports:
- nub_clkn  in  1  clock; all state changes on its rising edge.
- nub_reset  in  1  synchronous, active-high reset.
- nub_startn  in  1  bus START, active low.
- nub_ackn  in  1  bus ACK from another agent, active low.
- nub_tm1n  in  1  transfer mode 1: 1 = read, 0 = write.
- nub_tm0n  in  1  transfer mode 0: 0 = byte, 1 = half/word.
- nub_adn  in  32  multiplexed address/data, active low.
- nub_idn  in  4  slot ID, active low.
- mem_ready  in  1  memory done with the current access.
- mem_rdata  in  32  read data, valid with mem_ready.
- mem_valid_o  out  1  access request to memory.
- mem_write_o  out  4  byte-lane write enables.
- mem_addr_o  out  32  latched true-polarity address.
- mem_wdata_o  out  32  latched true-polarity write data.
- mem_myslot  out  1  latched address hits slot or super-slot space.
- mem_myexp  out  1  latched address hits expansion window.
- slv_slave_o  out  1  slave transaction in progress.
- slv_ackn_o  out  1  ACK driven by this slave, active low.
- slv_tm1n_o  out  1  status bit 1 driven during ACK.
- slv_tm0n_o  out  1  status bit 0 driven during ACK.
- slv_adn_o  out  32  read data to bus, active low.
- slv_ad_oe_o  out  1  enables slv_adn_o onto AD.
- slv_err_o  out  1  one-cycle pulse when an error or timeout status is issued.

Behaviour:
- States: IDLE, ACCESS, ACK. Reset (any cycle, including mid-transfer) forces IDLE with all state cleared.
- Reset values: mem_valid_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0, slv_ackn_o=1, slv_tm1n_o=1, slv_tm0n_o=1, slv_slave_o=0, slv_ad_oe_o=0, slv_adn_o=all 1s, slv_err_o=0, wait counter=0.
- Decode is combinational from the address: myslot = (addr[31:28]==SLOTS_ADDRESS & addr[27:24]==~nub_idn) | (SUPER_ENABLE & addr[31:28]==~nub_idn & ~nub_idn!=0). myexp = (addr[31:28]&EXPANSION_MASK)==EXPANSION_ADDR.
- mem_myslot and mem_myexp are these decodes evaluated on the latched address.
- IDLE: a start cycle is start=0, ack=1, and decode on ~nub_adn matches.
- On a start cycle, latch:
  - mem_addr_o <= ~nub_adn
  - the tm1n/tm0n mode bits
- Start with ack=0 (attention cycle) or with no decode match is ignored.
- Legal encodings go to ACCESS. Reserved encoding (tm0n=1, addr[1:0]=11) goes directly to ACK with error status; memory is never requested.
- ACCESS, first cycle:
  - mem_wdata_o <= ~nub_adn
  - mem_valid_o = 1 from the cycle after start
  - slv_slave_o = 1 in ACCESS and ACK
- Byte enables (mem_write_o), active only while mem_valid_o=1 and the latched tm1n=0:
  - byte (tm0n=0): lane addr[1:0]
  - addr[1:0]=00: word, 1111
  - addr[1:0]=01: half 0, 0011
  - addr[1:0]=10: half 1, 1100
- ACCESS, waiting:
  - Wait counter increments each cycle mem_ready=0.
  - mem_ready=1: capture ~mem_rdata into slv_adn_o if read; go to ACK with status complete (0,0); mem_valid_o drops next cycle.
  - Counter reaching TIMEOUT_CYCLES with mem_ready=0: ACK with status timeout (1,0).
  - mem_ready and timeout in the same cycle: ready wins.
- ACK lasts exactly one cycle:
  - slv_ackn_o=0; slv_tm1n_o/slv_tm0n_o carry the status.
  - slv_ad_oe_o=1 only for a read completed with complete status.
  - slv_err_o=1 for error or timeout status.
  - Next state is IDLE; counter cleared.
- Status encoding (tm1n,tm0n): complete 00, error 01, timeout 10.
- New START while in ACCESS/ACK is ignored (no re-latch).
- Latency: read/write with immediate ready gives ACK at start+2 cycles.

Test Plan:
- ID=~4'h3, write word to 0xF3000010, data 0xDEADBEEF, ready on first ACCESS cycle -> mem_write_o=1111, mem_wdata_o=DEADBEEF, ACK at start+2, status 00.
- Byte write 0xF3000013 (tm0n=0) -> mem_write_o=1000; half writes at 0x…11 and 0x…12 -> 0011 and 1100.
- Read 0xF3000000, ready after 3 waits with rdata 0x12345678 -> slv_adn_o=~12345678, slv_ad_oe_o=1 for exactly the ACK cycle.
- Super-slot read 0x30000000 with SUPER_ENABLE=1 -> serviced; same with SUPER_ENABLE=0 or ID 0 -> no response. Address 0xF4000000 -> no response.
- TIMEOUT_CYCLES=4, ready never asserted -> ACK with status 10 and slv_err_o pulse, mem_valid_o low afterwards; tm0n=1 with addr[1:0]=11 -> ACK status 01 at start+1, mem_valid_o never 1.
- Reset asserted during ACCESS -> next cycle all outputs at reset values; a subsequent transfer completes normally.
